wb_arbiter_nx1: RTL and testbench



---
 rtl/wb_arbiter_nx1_if.sv | 47 ++++
 rtl/wb_arbiter_nx1.sv | 194 +++++++++++++++++++
 tb/tb_wb_arbiter_nx1.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_nx1_if.sv
// Bundled Wishbone signals between N masters, the arbiter and one shared slave.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
`timescale 1ns/1ps

interface wb_arbiter_nx1_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int N  = 2
);
    logic [N*AW-1:0]     m_adr;
    logic [N*DW-1:0]     m_dat_w;
    logic [N*(DW/8)-1:0] m_sel;
    logic [N*3-1:0]      m_cti;
    logic [N*2-1:0]      m_bte;
    logic [N-1:0]        m_cyc;
    logic [N-1:0]        m_stb;
    logic [N-1:0]        m_we;
    logic [N*DW-1:0]     m_dat_r;
    logic [N-1:0]        m_ack;
    logic [N-1:0]        m_err;

    logic [AW-1:0]       s_adr;
    logic [DW-1:0]       s_dat_w;
    logic [DW/8-1:0]     s_sel;
    logic [2:0]          s_cti;
    logic [1:0]          s_bte;
    logic                s_cyc;
    logic                s_stb;
    logic                s_we;
    logic [DW-1:0]       s_dat_r;
    logic                s_ack;
    logic                s_err;

    modport slave (
        input  m_adr, m_dat_w, m_sel, m_cti, m_bte, m_cyc, m_stb, m_we,
        input  s_dat_r, s_ack, s_err,
        output m_dat_r, m_ack, m_err,
        output s_adr, s_dat_w, s_sel, s_cti, s_bte, s_cyc, s_stb, s_we
    );

    modport master (
        output m_adr, m_dat_w, m_sel, m_cti, m_bte, m_cyc, m_stb, m_we,
        output s_dat_r, s_ack, s_err,
        input  m_dat_r, m_ack, m_err,
        input  s_adr, s_dat_w, s_sel, s_cti, s_bte, s_cyc, s_stb, s_we
    );
endinterface

// File: rtl/wb_arbiter_nx1.sv
// Round-robin N:1 Wishbone arbiter; grant is locked for the whole CYC.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant, slave outputs held at 0, arbitrating on m_cyc
// BUSY  | granted master muxed straight through to the slave
// ABORT | watchdog fired: one-cycle m_err to the granted master, slave cycle dropped
// DRAIN | slave cycle dropped, waiting for the granted master to release CYC
`timescale 1ns/1ps

module wb_arbiter_nx1 #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rstn,
    wb_arbiter_nx1_if.slave      bus,
    output logic [N_MASTERS-1:0] gnt
);
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int LW = $clog2(N_MASTERS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [1:0] ST_ABORT = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;
`endif

    if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n
        $error("wb_arbiter_nx1: N_MASTERS must be 2..8");
    end
    if (WB_DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $error("wb_arbiter_nx1: WB_DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_to
        $error("wb_arbiter_nx1: TIMEOUT_CYCLES must be 2..65536");
    end

    logic [1:0]    state;
    // Index of the most recent grant; doubles as the mux select while a grant is held.
    logic [LW-1:0] last;

    logic          nxt_found;
    logic [LW-1:0] nxt_idx;
    logic [LW-1:0] cand;

    logic [AW-1:0]        s_adr_c;
    logic [DW-1:0]        s_dat_w_c;
    logic [SW-1:0]        s_sel_c;
    logic [2:0]           s_cti_c;
    logic [1:0]           s_bte_c;
    logic                 s_cyc_c;
    logic                 s_stb_c;
    logic                 s_we_c;
    logic [N_MASTERS*DW-1:0] m_dat_r_c;
    logic [N_MASTERS-1:0]    m_ack_c;
    logic [N_MASTERS-1:0]    m_err_c;

    logic          wd_fire;

    // Search starts one past the last winner and wraps, giving round-robin order.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = last;
        cand      = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = LW'((int'(last) + k) % N_MASTERS);
            if (!nxt_found && bus.m_cyc[cand]) begin
                nxt_found = 1'b1;
                nxt_idx   = cand;
            end
        end
    end

    always_comb begin
        s_adr_c   = '0;
        s_dat_w_c = '0;
        s_sel_c   = '0;
        s_cti_c   = '0;
        s_bte_c   = '0;
        s_cyc_c   = 1'b0;
        s_stb_c   = 1'b0;
        s_we_c    = 1'b0;
        m_dat_r_c = '0;
        m_ack_c   = '0;
        m_err_c   = '0;
        if (state == ST_BUSY) begin
            s_adr_c              = bus.m_adr[last*AW +: AW];
            s_dat_w_c            = bus.m_dat_w[last*DW +: DW];
            s_sel_c              = bus.m_sel[last*SW +: SW];
            s_cti_c              = bus.m_cti[last*3 +: 3];
            s_bte_c              = bus.m_bte[last*2 +: 2];
            s_cyc_c              = bus.m_cyc[last];
            s_stb_c              = bus.m_stb[last];
            s_we_c               = bus.m_we[last];
            m_dat_r_c[last*DW +: DW] = bus.s_dat_r;
            m_ack_c[last]        = bus.s_ack;
            m_err_c[last]        = bus.s_err;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (state == ST_ABORT) begin
            m_err_c[last] = 1'b1;
        end
`endif
    end

    assign bus.s_adr   = s_adr_c;
    assign bus.s_dat_w = s_dat_w_c;
    assign bus.s_sel   = s_sel_c;
    assign bus.s_cti   = s_cti_c;
    assign bus.s_bte   = s_bte_c;
    assign bus.s_cyc   = s_cyc_c;
    assign bus.s_stb   = s_stb_c;
    assign bus.s_we    = s_we_c;
    assign bus.m_dat_r = m_dat_r_c;
    assign bus.m_ack   = m_ack_c;
    assign bus.m_err   = m_err_c;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        wd_stall;

    // A stall is a live strobe from the granted master that the slave has not terminated.
    assign wd_stall = (state == ST_BUSY) && s_cyc_c && s_stb_c && !bus.s_ack && !bus.s_err;
    assign wd_fire  = wd_stall && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt <= '0;
        end else if (wd_stall && !wd_fire) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            gnt   <= '0;
            last  <= LW'(N_MASTERS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (nxt_found) begin
                        state <= ST_BUSY;
                        gnt   <= N_MASTERS'(1) << nxt_idx;
                        last  <= nxt_idx;
                    end
                end
                ST_BUSY: begin
                    if (!bus.m_cyc[last]) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (wd_fire) begin
                        state <= ST_ABORT;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!bus.m_cyc[last]) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

`ifndef WB_ARB_TIMEOUT_EN
    logic unused_wd;
    assign unused_wd = wd_fire;
`endif

endmodule

// File: tb/tb_wb_arbiter_nx1.sv
// Directed self-checking bench for wb_arbiter_nx1 with two masters.
// The watchdog scenario runs only when WB_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_wb_arbiter_nx1;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 2;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] gnt;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    wb_arbiter_nx1_if #(.AW(AW), .DW(DW), .N(N)) bus ();

    wb_arbiter_nx1 #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .N_MASTERS     (N),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus),
        .gnt (gnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic cyc, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        bus.m_cyc[i]            = cyc;
        bus.m_stb[i]            = cyc;
        bus.m_we[i]             = we;
        bus.m_adr[i*AW +: AW]   = adr;
        bus.m_dat_w[i*DW +: DW] = dat;
        bus.m_sel[i*4 +: 4]     = 4'hF;
        bus.m_cti[i*3 +: 3]     = cti;
        bus.m_bte[i*2 +: 2]     = 2'b00;
    endtask

    task automatic slave(input logic ack, input logic err, input logic [31:0] dat);
        bus.s_ack   = ack;
        bus.s_err   = err;
        bus.s_dat_r = dat;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        bus.m_adr = '0; bus.m_dat_w = '0; bus.m_sel = '0; bus.m_cti = '0; bus.m_bte = '0;
        bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0;
        slave(1'b1, 1'b1, 32'h5555_AAAA);
        #12;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        checks++; if (bus.s_cyc !== 1'b0 || bus.s_stb !== 1'b0 || bus.s_we !== 1'b0) begin errors++; $display("FAIL reset_s_ctrl: got cyc%b stb%b we%b want 000", bus.s_cyc, bus.s_stb, bus.s_we); end
        checks++; if (bus.s_adr !== 32'h0 || bus.s_dat_w !== 32'h0 || bus.s_sel !== 4'h0) begin errors++; $display("FAIL reset_s_data: got adr %h dat %h sel %h want 0", bus.s_adr, bus.s_dat_w, bus.s_sel); end
        checks++; if (bus.m_ack !== 2'b00 || bus.m_err !== 2'b00) begin errors++; $display("FAIL reset_m_resp: got ack %b err %b want 00", bus.m_ack, bus.m_err); end
        checks++; if (bus.m_dat_r !== 64'h0) begin errors++; $display("FAIL reset_m_dat_r: got %h want 0", bus.m_dat_r); end
        slave(1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_single();
        drive(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 3'b000);
        #1;
        checks++; if (bus.s_cyc !== 1'b0) begin errors++; $display("FAIL single_latency: got s_cyc %b want 0", bus.s_cyc); end
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", gnt); end
        checks++; if (bus.s_cyc !== 1'b1 || bus.s_stb !== 1'b1) begin errors++; $display("FAIL single_s_cyc: got cyc%b stb%b want 11", bus.s_cyc, bus.s_stb); end
        checks++; if (bus.s_adr !== 32'h0000_1000 || bus.s_we !== 1'b0) begin errors++; $display("FAIL single_s_adr: got %h we%b want 00001000 we0", bus.s_adr, bus.s_we); end
        tick();
        tick();
        slave(1'b1, 1'b0, 32'hCAFE_F00D);
        #1;
        checks++; if (bus.m_ack !== 2'b01) begin errors++; $display("FAIL single_ack: got %b want 01", bus.m_ack); end
        checks++; if (bus.m_dat_r !== 64'h0000_0000_CAFE_F00D) begin errors++; $display("FAIL single_dat_r: got %h want 00000000cafef00d", bus.m_dat_r); end
        tick();
        slave(1'b0, 1'b0, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        checks++; if (bus.s_cyc !== 1'b0) begin errors++; $display("FAIL single_release_s_cyc: got %b want 0", bus.s_cyc); end
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_idle_gnt: got %b want 00", gnt); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_seq [5];
        int         holder;
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        pulse_reset();
        drive(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b000);
        drive(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 3'b000);
        tick();
        for (int r = 0; r < 4; r++) begin
            holder = (exp_seq[r] == 2'b01) ? 0 : 1;
            checks++; if (gnt !== exp_seq[r]) begin errors++; $display("FAIL contention_gnt_round%0d: got %b want %b", r, gnt, exp_seq[r]); end
            slave(1'b1, 1'b0, 32'h0000_0010 + r);
            #1;
            checks++; if (bus.m_ack !== exp_seq[r]) begin errors++; $display("FAIL contention_ack_round%0d: got %b want %b", r, bus.m_ack, exp_seq[r]); end
            tick();
            slave(1'b0, 1'b0, 32'h0);
            drive(holder, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
            tick();
            checks++; if (gnt !== 2'b00 || bus.s_cyc !== 1'b0) begin errors++; $display("FAIL contention_idle_round%0d: got gnt %b s_cyc %b want 00 0", r, gnt, bus.s_cyc); end
            drive(holder, 1'b1, 1'b0, 32'h0000_0100 * (holder + 1), 32'h0, 3'b000);
            tick();
        end
        checks++; if (gnt !== exp_seq[4]) begin errors++; $display("FAIL contention_gnt_final: got %b want %b", gnt, exp_seq[4]); end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        tick();
    endtask

    task automatic test_burst();
        logic [2:0] cti;
        drive(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 3'b010);
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL burst_gnt_start: got %b want 10", gnt); end
        drive(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 3'b000);
        for (int b = 0; b < 4; b++) begin
            cti = (b == 3) ? 3'b111 : 3'b010;
            drive(1, 1'b1, 1'b0, 32'h0000_2000 + 4 * b, 32'h0, cti);
            slave(1'b1, 1'b0, 32'hB000_0000 + b);
            #1;
            checks++; if (gnt !== 2'b10 || bus.m_ack !== 2'b10) begin errors++; $display("FAIL burst_beat%0d: got gnt %b ack %b want 10 10", b, gnt, bus.m_ack); end
            checks++; if (bus.s_cti !== cti || bus.s_adr !== 32'h0000_2000 + 4 * b) begin errors++; $display("FAIL burst_addr%0d: got cti %b adr %h want %b %h", b, bus.s_cti, bus.s_adr, cti, 32'h0000_2000 + 4 * b); end
            checks++; if (bus.m_dat_r !== {32'hB000_0000 + b, 32'h0}) begin errors++; $display("FAIL burst_dat%0d: got %h want %h", b, bus.m_dat_r, {32'hB000_0000 + b, 32'h0}); end
            tick();
        end
        slave(1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL burst_idle: got %b want 00", gnt); end
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL burst_next_gnt: got %b want 01", gnt); end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        tick();
    endtask

    task automatic test_error();
        drive(1, 1'b1, 1'b1, 32'h0000_3000, 32'h1234_5678, 3'b000);
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL error_gnt: got %b want 10", gnt); end
        checks++; if (bus.s_we !== 1'b1 || bus.s_dat_w !== 32'h1234_5678) begin errors++; $display("FAIL error_write: got we%b dat %h want 1 12345678", bus.s_we, bus.s_dat_w); end
        drive(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 3'b000);
        slave(1'b0, 1'b1, 32'h0);
        #1;
        checks++; if (bus.m_err !== 2'b10 || bus.m_ack !== 2'b00) begin errors++; $display("FAIL error_pass: got err %b ack %b want 10 00", bus.m_err, bus.m_ack); end
        tick();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (bus.m_err !== 2'b00 || gnt !== 2'b10) begin errors++; $display("FAIL error_hold1: got err %b gnt %b want 00 10", bus.m_err, gnt); end
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL error_hold2: got %b want 10", gnt); end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL error_idle: got %b want 00", gnt); end
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL error_next_gnt: got %b want 01", gnt); end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        tick();
    endtask

    task automatic test_stray_ack();
        slave(1'b1, 1'b1, 32'hFFFF_FFFF);
        #1;
        checks++; if (bus.m_ack !== 2'b00 || bus.m_err !== 2'b00) begin errors++; $display("FAIL stray_resp: got ack %b err %b want 00 00", bus.m_ack, bus.m_err); end
        checks++; if (bus.m_dat_r !== 64'h0) begin errors++; $display("FAIL stray_dat_r: got %h want 0", bus.m_dat_r); end
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL stray_gnt: got %b want 00", gnt); end
        slave(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_burst();
        drive(0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 3'b010);
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rstmid_gnt: got %b want 01", gnt); end
        slave(1'b1, 1'b0, 32'h0);
        tick();
        drive(0, 1'b1, 1'b0, 32'h0000_5004, 32'h0, 3'b010);
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (gnt !== 2'b00 || bus.s_cyc !== 1'b0) begin errors++; $display("FAIL rstmid_clear: got gnt %b s_cyc %b want 00 0", gnt, bus.s_cyc); end
        checks++; if (bus.m_ack !== 2'b00) begin errors++; $display("FAIL rstmid_ack: got %b want 00", bus.m_ack); end
        slave(1'b0, 1'b0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 3'b000);
        tick();
        rstn = 1'b1;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rstmid_first_gnt: got %b want 01", gnt); end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        drive(0, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 3'b000);
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL timeout_gnt: got %b want 01", gnt); end
        for (int i = 1; i <= 15; i++) tick();
        checks++; if (bus.m_err !== 2'b00 || bus.s_cyc !== 1'b1) begin errors++; $display("FAIL timeout_early: got err %b s_cyc %b want 00 1", bus.m_err, bus.s_cyc); end
        tick();
        checks++; if (bus.m_err !== 2'b01 || bus.s_cyc !== 1'b0) begin errors++; $display("FAIL timeout_abort: got err %b s_cyc %b want 01 0", bus.m_err, bus.s_cyc); end
        slave(1'b1, 1'b0, 32'hDEAD_BEEF);
        #1;
        checks++; if (bus.m_ack !== 2'b00) begin errors++; $display("FAIL timeout_late_ack_abort: got %b want 00", bus.m_ack); end
        tick();
        checks++; if (bus.m_ack !== 2'b00 || bus.m_err !== 2'b00 || gnt !== 2'b01) begin errors++; $display("FAIL timeout_drain: got ack %b err %b gnt %b want 00 00 01", bus.m_ack, bus.m_err, gnt); end
        slave(1'b0, 1'b0, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL timeout_idle: got %b want 00", gnt); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_burst();
        test_error();
        test_stray_ack();
        test_reset_mid_burst();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
